mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one memory bus port between the IF-stage fetch requester and the MEM-stage load/store requester of rvcpu.
//  Grants one requester at a time with a registered, locked request and routes the response back to the owner only.
//  MEM normally wins; a starvation counter forces an IF grant after STARVE_MAX consecutive contested MEM grants.
//  Sits between rvcpu (if_*/mem_* ports) and the SoC-side memory/AXI bridge (bus_* ports).
// PARAMETERS
//  STARVE_MAX  3  contested MEM grants allowed before IF is forced; range 1..15; counter width 4 bits
// PORTS
//  clk             in   1   clock; all state updates on rising edge
//  rst             in   1   reset, asynchronous, active-low (0 = reset)
//  if_valid        in   1   fetch request pending; held until if_ready
//  if_addr         in   64  fetch address (`REG_BUS)
//  if_size         in   2   fetch size
//  if_ready        out  1   1-cycle completion pulse to IF
//  if_resp         out  2   response code to IF, valid with if_ready
//  if_data_read    out  64  fetched data, valid with if_ready
//  mem_valid       in   1   load/store request pending; held until mem_ready
//  mem_req         in   2   request type (`REQ_READ / `REQ_WRITE)
//  mem_addr        in   64  data address
//  mem_data_write  in   64  store data
//  mem_size        in   2   access size
//  mem_ready       out  1   1-cycle completion pulse to MEM
//  mem_resp        out  2   response code to MEM, valid with mem_ready
//  mem_data_read   out  64  load data, valid with mem_ready
//  bus_valid       out  1   request to memory side; held until bus_ready
//  bus_req         out  2   request type (fetch always `REQ_READ)
//  bus_addr        out  64  address
//  bus_data_write  out  64  write data (0 for fetch)
//  bus_size        out  2   size
//  bus_ready       in   1   1-cycle completion pulse from memory side
//  bus_resp        in   2   response code, valid with bus_ready
//  bus_data_read   in   64  read data, valid with bus_ready
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, starve_cnt=0, all bus_* outputs 0; if_ready=mem_ready=0, resp/data outputs 0.
//  FSM states: IDLE, GNT_IF, GNT_MEM.
//  IDLE: arbitrate on current-cycle valids:
//   - mem_valid & (!if_valid | starve_cnt<STARVE_MAX) -> GNT_MEM; if_valid also high -> starve_cnt+1 (saturating).
//   - else if_valid -> GNT_IF; starve_cnt<=0.
//   - neither -> stay IDLE.
//  On the grant edge, latch the winner's req/addr/wdata/size into bus_* regs and set bus_valid=1.
//  Latency: grant in cycle N -> bus_valid=1 in cycle N+1; bus_* are stable while bus_valid=1.
//  GNT_x: wait for bus_ready; in that cycle forward bus_resp/bus_data_read to owner and pulse owner's ready (combinational).
//   Next edge: bus_valid<=0, state<=IDLE. Minimum 1 IDLE cycle between transactions (3-cycle minimum turnaround).
//  Non-owner ready is always 0; non-owner resp/data are 0. Owner resp/data are 0 when bus_ready=0.
//  bus_ready while IDLE: ignored, with no pulse to either requester.
//  Requester drops valid mid-grant: transaction still completes; ready pulse is still issued.
//  Non-zero bus_resp (error): forwarded unchanged; transaction completes normally, with no retry.
//  starve_cnt is unchanged by uncontested MEM grants and by idle cycles.
//  Async reset mid-transaction abandons the transaction immediately; the memory side must be reset with it.
// STRUCTURE
//  `REQ_READ=2'b00, `REQ_WRITE=2'b01, `RESP_OKAY=2'b00, and FSM state encodings go in defines.v.
//  Single module; no sub-module. Grant/priority logic is a small combinational block feeding the FSM registers.
// TESTING
//  1 Reset: rst=0 mid-GNT_MEM with bus_valid=1 -> all outputs 0 asynchronously; IDLE after release.
//  2 Lone IF: if_valid, addr 0x8000_0000 -> bus_valid in cycle+1, bus_req=READ; bus_ready+data 0x13 -> if_ready pulse, data 0x13, mem_ready=0.
//  3 Contention: both valid, starve_cnt=0 -> MEM granted first; IF granted after MEM completes.
//  4 Starvation: STARVE_MAX=3, if_valid held, 4 back-to-back MEM requests -> 4th grant goes to IF; starve_cnt=0.
//  5 Store: mem_req=WRITE, addr 0x8000_1000, wdata 0xDEAD_BEEF, size 2'b11 -> bus_* match exactly; bus_resp=2'b10 forwarded to mem_resp.
//  6 Stray/drop: bus_ready in IDLE -> no ready pulse; IF valid dropped after grant -> if_ready still pulses once.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned REQ_W  = 2;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned RESP_W = 2;
  localparam int unsigned CNT_W  = 4;

  localparam logic [REQ_W-1:0]  REQ_READ  = 2'b00;
  localparam logic [REQ_W-1:0]  REQ_WRITE = 2'b01;
  localparam logic [RESP_W-1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_IF  = 2'd1,
    ST_GNT_MEM = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [REQ_W-1:0]  req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [SIZE_W-1:0] size;
  } bus_req_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus port between IF fetches and MEM loads/stores.
// MEM has priority; a starvation counter forces an IF grant after STARVE_MAX contested MEM wins.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [SIZE_W-1:0] if_size,
  output logic              if_ready,
  output logic [RESP_W-1:0] if_resp,
  output logic [DATA_W-1:0] if_data_read,
  input  logic              mem_valid,
  input  logic [REQ_W-1:0]  mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data_write,
  input  logic [SIZE_W-1:0] mem_size,
  output logic              mem_ready,
  output logic [RESP_W-1:0] mem_resp,
  output logic [DATA_W-1:0] mem_data_read,
  output logic              bus_valid,
  output logic [REQ_W-1:0]  bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_data_write,
  output logic [SIZE_W-1:0] bus_size,
  input  logic              bus_ready,
  input  logic [RESP_W-1:0] bus_resp,
  input  logic [DATA_W-1:0] bus_data_read
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  bus_req_t         bus_q, bus_d;
  logic             bus_valid_q, bus_valid_d;
  logic             mem_win_c;

  // Priority: MEM wins unless IF has been passed over STARVE_MAX times in a row.
  assign mem_win_c = mem_valid && (!if_valid || (starve_q < STARVE_LIM));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      bus_q       <= '0;
      bus_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      bus_q       <= bus_d;
      bus_valid_q <= bus_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    bus_d       = bus_q;
    bus_valid_d = bus_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_win_c) begin
          state_d     = ST_GNT_MEM;
          bus_valid_d = 1'b1;
          bus_d       = '{req: mem_req, addr: mem_addr, wdata: mem_data_write, size: mem_size};
          if (if_valid && (starve_q != CNT_SAT)) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end else if (if_valid) begin
          state_d     = ST_GNT_IF;
          bus_valid_d = 1'b1;
          bus_d       = '{req: REQ_READ, addr: if_addr, wdata: '0, size: if_size};
          starve_d    = '0;
        end
      end
      ST_GNT_IF, ST_GNT_MEM: begin
        if (bus_ready) begin
          state_d     = ST_IDLE;
          bus_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        bus_valid_d = 1'b0;
      end
    endcase
  end

  assign bus_valid      = bus_valid_q;
  assign bus_req        = bus_q.req;
  assign bus_addr       = bus_q.addr;
  assign bus_data_write = bus_q.wdata;
  assign bus_size       = bus_q.size;

  // Completion is steered only to the current owner; bus_ready in IDLE reaches nobody.
  assign if_ready      = (state_q == ST_GNT_IF) && bus_ready;
  assign mem_ready     = (state_q == ST_GNT_MEM) && bus_ready;
  assign if_resp       = if_ready  ? bus_resp      : '0;
  assign if_data_read  = if_ready  ? bus_data_read : '0;
  assign mem_resp      = mem_ready ? bus_resp      : '0;
  assign mem_data_read = mem_ready ? bus_data_read : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: driver predicts bus requests and responses
// from a transaction-level arbitration model; a negedge monitor pops and compares.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int unsigned STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [63:0] if_addr;
  logic [1:0]  if_size;
  logic        if_ready;
  logic [1:0]  if_resp;
  logic [63:0] if_data_read;
  logic        mem_valid;
  logic [1:0]  mem_req;
  logic [63:0] mem_addr;
  logic [63:0] mem_data_write;
  logic [1:0]  mem_size;
  logic        mem_ready;
  logic [1:0]  mem_resp;
  logic [63:0] mem_data_read;
  logic        bus_valid;
  logic [1:0]  bus_req;
  logic [63:0] bus_addr;
  logic [63:0] bus_data_write;
  logic [1:0]  bus_size;
  logic        bus_ready;
  logic [1:0]  bus_resp;
  logic [63:0] bus_data_read;

  mem_bus_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_addr(if_addr), .if_size(if_size),
    .if_ready(if_ready), .if_resp(if_resp), .if_data_read(if_data_read),
    .mem_valid(mem_valid), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data_write(mem_data_write), .mem_size(mem_size),
    .mem_ready(mem_ready), .mem_resp(mem_resp), .mem_data_read(mem_data_read),
    .bus_valid(bus_valid), .bus_req(bus_req), .bus_addr(bus_addr),
    .bus_data_write(bus_data_write), .bus_size(bus_size),
    .bus_ready(bus_ready), .bus_resp(bus_resp), .bus_data_read(bus_data_read)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          owner;   // 0 none, 1 IF, 2 MEM
    logic [1:0]  resp;
    logic [63:0] data;
  } rsp_t;

  bus_req_t q_bus[$];
  rsp_t     q_rsp[$];
  int       n_cmp = 0;
  int       n_bad = 0;

  // Transaction-level reference state
  bit       pend_if = 0, pend_mem = 0;
  int       starve = 0;
  bit       fix_rsp = 0, force_stray = 0, force_drop = 0;
  logic [1:0]  fix_resp;
  logic [63:0] fix_data;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares bus requests and requester responses against the scoreboard.
  bit       bv_prev = 0;
  bus_req_t cur;
  always @(negedge clk) begin
    bus_req_t e;
    rsp_t     r;
    if (rst) begin
      if (bus_valid && !bv_prev) begin
        if (q_bus.size() == 0) begin
          check("unexpected_bus_valid", 64'd1, 64'd0);
        end else begin
          e = q_bus.pop_front();
          cur = e;
          check("bus_req", 64'(bus_req), 64'(e.req));
          check("bus_addr", bus_addr, e.addr);
          check("bus_data_write", bus_data_write, e.wdata);
          check("bus_size", 64'(bus_size), 64'(e.size));
        end
      end else if (bus_valid) begin
        check("bus_stable", {bus_addr[61:0], bus_req}, {cur.addr[61:0], cur.req});
      end
      if (bus_ready) begin
        if (q_rsp.size() == 0) begin
          check("unexpected_bus_ready", 64'd1, 64'd0);
        end else begin
          r = q_rsp.pop_front();
          check("if_ready", 64'(if_ready), 64'(r.owner == 1));
          check("mem_ready", 64'(mem_ready), 64'(r.owner == 2));
          check("if_resp", 64'(if_resp), (r.owner == 1) ? 64'(r.resp) : 64'd0);
          check("mem_resp", 64'(mem_resp), (r.owner == 2) ? 64'(r.resp) : 64'd0);
          check("if_data_read", if_data_read, (r.owner == 1) ? r.data : 64'd0);
          check("mem_data_read", mem_data_read, (r.owner == 2) ? r.data : 64'd0);
        end
      end else begin
        check("quiet_ctrl", 64'({if_ready, mem_ready, if_resp, mem_resp}), 64'd0);
        check("quiet_data", if_data_read | mem_data_read, 64'd0);
      end
    end
    bv_prev = bus_valid;
  end

  task automatic new_reqs(input int p_if, input int p_mem);
    if (!pend_if && ($urandom_range(0, 99) < p_if)) begin
      pend_if  = 1;
      if_valid = 1'b1;
      if_addr  = {$urandom, $urandom & 32'hFFFF_FFFC};
      if_size  = 2'($urandom_range(0, 3));
    end
    if (!pend_mem && ($urandom_range(0, 99) < p_mem)) begin
      pend_mem       = 1;
      mem_valid      = 1'b1;
      mem_req        = 2'($urandom_range(0, 1));
      mem_addr       = {$urandom, $urandom};
      mem_data_write = {$urandom, $urandom};
      mem_size       = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic junk_bus();
    bus_resp      = 2'($urandom);
    bus_data_read = {$urandom, $urandom};
  endtask

  // One arbitration round; entered and left #1 after a rising edge with the DUT idle.
  task automatic run_round();
    bus_req_t e;
    rsp_t     r;
    int       owner;
    if (!pend_if && !pend_mem) begin
      if (force_stray || ($urandom_range(0, 2) == 0)) begin
        bus_ready = 1'b1;
        junk_bus();
        r.owner = 0; r.resp = bus_resp; r.data = bus_data_read;
        q_rsp.push_back(r);
        @(posedge clk); #1;
        bus_ready = 1'b0;
        junk_bus();
      end else begin
        @(posedge clk); #1;
      end
      return;
    end
    if (pend_mem && (!pend_if || (starve < int'(STARVE_MAX)))) begin
      if (pend_if && starve < 15) starve++;
      e = '{req: mem_req, addr: mem_addr, wdata: mem_data_write, size: mem_size};
      owner = 2;
    end else begin
      starve = 0;
      e = '{req: REQ_READ, addr: if_addr, wdata: 64'd0, size: if_size};
      owner = 1;
    end
    q_bus.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check("grant_latency", 64'(bus_valid), 64'd1);
    if (force_drop || ($urandom_range(0, 9) == 0)) begin
      if (owner == 1) if_valid = 1'b0;
      else mem_valid = 1'b0;
    end
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #1;
    bus_ready = 1'b1;
    if (fix_rsp) begin
      bus_resp = fix_resp; bus_data_read = fix_data;
    end else begin
      junk_bus();
    end
    r.owner = owner; r.resp = bus_resp; r.data = bus_data_read;
    q_rsp.push_back(r);
    @(posedge clk); #1;
    bus_ready = 1'b0;
    junk_bus();
    if (owner == 1) begin pend_if = 0; if_valid = 1'b0; end
    else begin pend_mem = 0; mem_valid = 1'b0; end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_ctrl"}, 64'({bus_valid, bus_req, bus_size, if_ready, mem_ready, if_resp, mem_resp}), 64'd0);
    check({nm, "_addr_wdata"}, bus_addr | bus_data_write, 64'd0);
    check({nm, "_rdata"}, if_data_read | mem_data_read, 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    if_valid = 0; if_addr = 0; if_size = 0;
    mem_valid = 0; mem_req = 0; mem_addr = 0; mem_data_write = 0; mem_size = 0;
    bus_ready = 0; bus_resp = 0; bus_data_read = 0;
    fix_resp = 0; fix_data = 0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    junk_bus();

    // Lone fetch returning 0x13
    pend_if = 1; if_valid = 1'b1; if_addr = 64'h0000_0000_8000_0000; if_size = 2'b10;
    fix_rsp = 1; fix_resp = RESP_OKAY; fix_data = 64'h13;
    run_round();
    fix_rsp = 0;

    // Contention from a fresh counter: MEM first, then IF
    new_reqs(100, 100);
    run_round();
    run_round();

    // Starvation: IF held while MEM keeps re-requesting
    for (int i = 0; i < 6; i++) begin
      new_reqs(100, 100);
      run_round();
    end
    while (pend_if || pend_mem) run_round();

    // Store with an error response
    pend_mem = 1; mem_valid = 1'b1; mem_req = REQ_WRITE;
    mem_addr = 64'h0000_0000_8000_1000; mem_data_write = 64'h0000_0000_DEAD_BEEF; mem_size = 2'b11;
    fix_rsp = 1; fix_resp = 2'b10; fix_data = 64'h0;
    run_round();
    fix_rsp = 0;

    // Stray bus_ready while idle, then a fetch whose valid drops mid-grant
    force_stray = 1; run_round(); force_stray = 0;
    pend_if = 1; if_valid = 1'b1; if_addr = 64'h0000_0000_8000_0040; if_size = 2'b10;
    force_drop = 1; run_round(); force_drop = 0;

    // Randomized traffic with varying request pressure
    for (int i = 0; i < 300; i++) begin
      case (i / 75)
        0:       new_reqs(90, 90);
        1:       new_reqs(30, 80);
        2:       new_reqs(80, 30);
        default: new_reqs(50, 50);
      endcase
      run_round();
    end
    while (pend_if || pend_mem) run_round();

    // Asynchronous reset in the middle of a MEM grant
    pend_mem = 1; mem_valid = 1'b1; mem_req = REQ_READ;
    mem_addr = 64'h0000_0000_8000_2000; mem_data_write = 64'h0; mem_size = 2'b11;
    q_bus.push_back('{req: REQ_READ, addr: mem_addr, wdata: 64'h0, size: 2'b11});
    @(posedge clk);
    @(negedge clk);
    check("pre_reset_bus_valid", 64'(bus_valid), 64'd1);
    #2; rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    pend_mem = 0; mem_valid = 1'b0; starve = 0;
    @(posedge clk); #1; rst = 1'b1;

    // Back in IDLE: a fetch is served normally
    new_reqs(100, 0);
    run_round();

    repeat (3) @(posedge clk);
    #1;
    check("bus_queue_drained", 64'(q_bus.size()), 64'd0);
    check("rsp_queue_drained", 64'(q_rsp.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
